// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: multi-cycle mult/multu/div/divu plus mthi/mtlo.
// Operands are latched at issue; results land in HI/LO on the final Busy cycle.
module mult_div_unit #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW = $clog2(MaxCycles + 1);

   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e            state;
   logic [CntW-1:0]   cnt;
   logic [31:0]       a_q, b_q;
   logic [2:0]        op_q;

   logic [63:0]       prod;
   logic              a_neg, b_neg;
   logic [31:0]       a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

   // Signed division is done on magnitudes so 0x80000000 / -1 needs no special case.
   always_comb begin
      if (op_q == OpMult) begin
         prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      end else begin
         prod = {32'b0, a_q} * {32'b0, b_q};
      end
      a_neg   = (op_q == OpDiv) && a_q[31];
      b_neg   = (op_q == OpDiv) && b_q[31];
      a_mag   = a_neg ? -a_q : a_q;
      b_mag   = b_neg ? -b_q : b_q;
      divisor = (b_mag == 32'b0) ? 32'd1 : b_mag;
      q_mag   = a_mag / divisor;
      r_mag   = a_mag % divisor;
      quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem     = a_neg ? -r_mag : r_mag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= StIdle;
         cnt   <= '0;
         Busy  <= 1'b0;
         HI    <= 32'b0;
         LO    <= 32'b0;
         a_q   <= 32'b0;
         b_q   <= 32'b0;
         op_q  <= 3'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (Start) begin
                  case (MDOp)
                     OpMult, OpMultu: begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= MDOp;
                        cnt   <= CntW'(MUL_CYCLES);
                        state <= StMul;
                        Busy  <= 1'b1;
                     end
                     OpDiv, OpDivu: begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= MDOp;
                        cnt   <= CntW'(DIV_CYCLES);
                        state <= StDiv;
                        Busy  <= 1'b1;
                     end
                     OpMthi:  HI <= A;
                     OpMtlo:  LO <= A;
                     default: ;
                  endcase
               end
            end
            StMul, StDiv: begin
               cnt <= cnt - 1'b1;
               if (cnt == CntW'(1)) begin
                  state <= StIdle;
                  Busy  <= 1'b0;
                  if (state == StMul) begin
                     HI <= prod[63:32];
                     LO <= prod[31:0];
                  end else if (b_q != 32'b0) begin
                     HI <= rem;
                     LO <= quo;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;

   localparam int unsigned MulN = 5;
   localparam int unsigned DivN = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic [2:0]  MDOp;
   logic        Start;
   logic        Busy;
   logic [31:0] HI, LO;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] m_hi, m_lo;

   mult_div_unit #(.MUL_CYCLES(MulN), .DIV_CYCLES(DivN)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .MDOp  (MDOp),
      .Start (Start),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic on the issued operands.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: begin pu = {32'b0, a} * {32'b0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
         3'd3: if (b != 0) begin
            p = sa / sb; m_lo = p[31:0];
            p = sa % sb; m_hi = p[31:0];
         end
         3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
         default: ;
      endcase
   endtask

   // Issue one op at the next edge, then follow it to completion; returns #1 after
   // the edge on which Busy fell, so a following call issues back-to-back.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, input string name);
      int          n, exp_n;
      logic [31:0] pre_hi, pre_lo;
      A = a; B = b; MDOp = op; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      exp_n = (op == 3'd1 || op == 3'd2) ? MulN : (op == 3'd3 || op == 3'd4) ? DivN : 0;
      pre_hi = m_hi; pre_lo = m_lo;
      n = 0;
      while (Busy && n < 60) begin
         n++;
         vectors++;
         if (HI !== pre_hi || LO !== pre_lo) begin
            errors++;
            $display("FAIL %s hilo_stable: HI=%h LO=%h required HI=%h LO=%h",
                     name, HI, LO, pre_hi, pre_lo);
         end
         if (noise) begin
            A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7)); Start = 1'b1;
         end
         @(posedge clk); #1;
      end
      Start = 1'b0;
      vectors++;
      if (n != exp_n) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d required %0d", name, n, exp_n);
      end
      model(op, a, b);
      vectors++;
      if (HI !== m_hi || LO !== m_lo || Busy !== 1'b0) begin
         errors++;
         $display("FAIL %s result: HI=%h LO=%h Busy=%b required HI=%h LO=%h Busy=0",
                  name, HI, LO, Busy, m_hi, m_lo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      m_hi = 32'b0; m_lo = 32'b0;
      vectors++;
      if (Busy !== 1'b0 || HI !== 32'b0 || LO !== 32'b0) begin
         errors++;
         $display("FAIL reset_state: Busy=%b HI=%h LO=%h required 0/0/0", Busy, HI, LO);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 1'b0, "mult_neg2x3");
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
      run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 1'b0, "div_neg7by2");
      run_op(3'd4, 32'h00000007, 32'h00000000, 1'b0, "divu_by_zero");
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
      run_op(3'd3, 32'h00001234, 32'h00000000, 1'b0, "div_by_zero");
      run_op(3'd4, 32'hFFFFFFF9, 32'h00000002, 1'b0, "divu_big");
   endtask

   task automatic test_mthi_mtlo();
      run_op(3'd5, 32'h12345678, 32'h0, 1'b0, "mthi");
      run_op(3'd6, 32'h9ABCDEF0, 32'h0, 1'b0, "mtlo");
      // mult issued, then an mtlo attempt while Busy must not reach LO
      A = 32'h00000006; B = 32'h00000007; MDOp = 3'd1; Start = 1'b1;
      @(posedge clk); #1;
      A = 32'hDEADBEEF; MDOp = 3'd6; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      vectors++;
      if (LO !== m_lo || Busy !== 1'b1) begin
         errors++;
         $display("FAIL mtlo_while_busy: LO=%h Busy=%b required LO=%h Busy=1", LO, Busy, m_lo);
      end
      repeat (MulN) @(posedge clk);
      #1;
      model(3'd1, 32'h6, 32'h7);
      vectors++;
      if (HI !== m_hi || LO !== m_lo || Busy !== 1'b0) begin
         errors++;
         $display("FAIL mult_after_mtlo: HI=%h LO=%h Busy=%b required HI=%h LO=%h Busy=0",
                  HI, LO, Busy, m_hi, m_lo);
      end
      // MDOp 000 / 111 with Start must be no-ops
      for (int i = 0; i < 2; i++) begin
         A = $urandom; MDOp = (i == 0) ? 3'd0 : 3'd7; Start = 1'b1;
         @(posedge clk); #1;
         Start = 1'b0;
         vectors++;
         if (HI !== m_hi || LO !== m_lo || Busy !== 1'b0) begin
            errors++;
            $display("FAIL nop_op%0d: HI=%h LO=%h Busy=%b required HI=%h LO=%h Busy=0",
                     MDOp, HI, LO, Busy, m_hi, m_lo);
         end
      end
   endtask

   task automatic test_reset_mid();
      A = 32'd100; B = 32'd7; MDOp = 3'd3; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      m_hi = 32'b0; m_lo = 32'b0;
      vectors++;
      if (Busy !== 1'b0 || HI !== 32'b0 || LO !== 32'b0) begin
         errors++;
         $display("FAIL reset_mid_op: Busy=%b HI=%h LO=%h required 0/0/0", Busy, HI, LO);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      run_op(3'd1, 32'h00010000, 32'hFFFF0000, 1'b0, "mult_after_reset");
   endtask

   task automatic test_back_to_back();
      run_op(3'd1, 32'h7FFFFFFF, 32'h80000000, 1'b1, "b2b_mult");
      run_op(3'd2, 32'h80000001, 32'h00000003, 1'b1, "b2b_multu");
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(1, 6));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'b0;
            1: b = 32'hFFFFFFFF;
            2: a = 32'h80000000;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op(op, a, b, 1'b1, $sformatf("rand%0d_op%0d", i, op));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mthi_mtlo();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL take parameter MUL_CYCLES, default 5, meaning the number of Busy cycles for mult/multu.
REQ-002 SHALL take parameter DIV_CYCLES, default 10, meaning the number of Busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port A, input, 32 bits: operand rs, the same operand bus the EX-stage ALU consumes.
REQ-006 SHALL have port B, input, 32 bits: operand rt.
REQ-007 SHALL have port MDOp, input, 3 bits: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-008 SHALL have port Start, input, 1 bit: qualifies MDOp for one cycle.
REQ-009 SHALL have port Busy, output, 1 bit: an operation is in flight.
REQ-010 SHALL have port HI, output, 32 bits: registered HI value.
REQ-011 SHALL have port LO, output, 32 bits: registered LO value.

Function
REQ-012 SHALL implement states IDLE, MUL and DIV, plus a down-counter of width ceil(log2(max(MUL_CYCLES,DIV_CYCLES)+1)).
REQ-013 SHALL behave as follows in IDLE when Start=1 and MDOp is mult/multu/div/divu at edge T0:
- latch A, B and the op;
- go to MUL or DIV;
- load the counter with MUL_CYCLES or DIV_CYCLES;
- set Busy=1 from T0 onward.
REQ-014 SHALL decrement the counter on every edge while in MUL or DIV; on the edge where it reaches 0, HI/LO SHALL be written, Busy SHALL clear and the state SHALL return to IDLE, so Busy is high for exactly N cycles.
REQ-015 SHALL compute results from the latched operands only; A/B changes after T0 have no effect.
REQ-016 SHALL produce for mult the signed 64-bit product, split {HI,LO}; for multu, the unsigned 64-bit product.
REQ-017 SHALL produce for div LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend; for divu, the unsigned quotient/remainder.
REQ-018 SHALL, for div with 0x80000000 / 0xFFFFFFFF, give LO=0x80000000 and HI=0x00000000.
REQ-019 SHALL, for division by zero (div or divu), still assert Busy for DIV_CYCLES and then leave HI and LO unchanged.
REQ-020 SHALL, for Start=1 with mthi (mtlo) in IDLE, write A to HI (LO) at that edge, leave Busy at 0 and leave the state at IDLE.
REQ-021 SHALL ignore Start entirely while Busy=1: no restart, no mthi/mtlo and no latch change; the hazard unit stalls upstream.
REQ-022 SHALL ignore Start with MDOp 000 or 111 (no state change).
REQ-023 SHALL keep HI/LO stable except at a completion edge, an mthi/mtlo edge or reset.
REQ-024 SHALL allow Start on the edge after Busy falls, which begins a new operation normally (back-to-back issue).
REQ-025 SHALL be purely registered on Busy, HI and LO, with no combinational path from inputs.

Reset
REQ-026 SHALL, while reset=1 (asynchronous), force state=IDLE, counter=0, Busy=0, HI=0x00000000, LO=0x00000000 and clear the latched operands.
REQ-027 SHALL, on reset asserted mid-operation, abort the operation with no partial HI/LO update; after reset deasserts the block is IDLE and accepts Start on the next edge.

Verification
REQ-028 SHALL cover mult: A=0xFFFFFFFE (-2), B=0x00000003, Start with MDOp=001 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 SHALL cover multu: A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 SHALL cover div: A=0xFFFFFFF9 (-7), B=0x00000002 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 -> Busy for 10 cycles, HI/LO unchanged.
REQ-031 SHALL cover mthi with A=0x12345678 -> HI=0x12345678 at the same edge and Busy stays 0; then mtlo while Busy=1 -> LO unchanged.
REQ-032 SHALL cover Start div, then reset pulsed at cycle 4 -> HI=LO=0 and Busy=0 immediately; mult started after reset completes correctly.
REQ-033 SHALL cover back-to-back operation: mult completes, and Start multu on the following edge -> second Busy window of 5 cycles with a correct result; A changed mid-operation does not alter the result.
